// File: rtl/if_prefetch.sv
// Instruction prefetch unit: in-order ROM fetch into a small PC-tagged FIFO with redirect flush.
// Optional performance counters are enabled with `define IF_PREFETCH_PERF_EN.
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [DATA_W-1:0] inst_data,
    input  logic              inst_ready
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int              PTR_W = $clog2(DEPTH);
    localparam int              CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  LIMIT = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, resp_pc_q, redirect_pc;
    logic [CNT_W-1:0]   occ_q, occ_d, outst_q, outst_d, discard_q, discard_d;
    logic [CNT_W:0]     total;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [ADDR_W-1:0]  fifo_pc   [DEPTH];
    logic [DATA_W-1:0]  fifo_data [DEPTH];
    logic               grant, rv, push, pop;

    assign redirect_pc = {redirect_addr[ADDR_W-1:2], 2'b00};
    assign total       = {1'b0, occ_q} + {1'b0, outst_q};
    assign mem_req     = (state_q == RUN) && (total < LIMIT) && !redirect_valid;
    assign mem_addr    = fetch_pc_q;
    assign grant       = mem_req && mem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign rv          = mem_rvalid && (outst_q != '0);
    assign push        = rv && (discard_q == '0) && !redirect_valid;
    assign inst_valid  = (occ_q != '0);
    assign pop         = inst_valid && inst_ready && !redirect_valid;
    assign inst_pc     = inst_valid ? fifo_pc[rd_ptr_q]   : '0;
    assign inst_data   = inst_valid ? fifo_data[rd_ptr_q] : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        outst_d   = outst_q;
        discard_d = discard_q;

        if (grant && !rv)      outst_d = outst_q + CNT_W'(1);
        else if (!grant && rv) outst_d = outst_q - CNT_W'(1);

        if (redirect_valid)    occ_d = '0;
        else if (push && !pop) occ_d = occ_q + CNT_W'(1);
        else if (pop && !push) occ_d = occ_q - CNT_W'(1);

        // No grant can coincide with a redirect, so outst_d is exactly the surviving in-flight count.
        if (redirect_valid && state_q != DRAIN) discard_d = outst_d;
        else if (rv && discard_q != '0)         discard_d = discard_q - CNT_W'(1);

        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect_valid && discard_d != '0) state_d = DRAIN;
            DRAIN:   if (discard_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            occ_q      <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;

            if (redirect_valid) fetch_pc_q <= redirect_pc;
            else if (grant)     fetch_pc_q <= fetch_pc_q + ADDR_W'(4);

            if (redirect_valid) resp_pc_q <= redirect_pc;
            else if (push)      resp_pc_q <= resp_pc_q + ADDR_W'(4);

            if (redirect_valid) rd_ptr_q <= '0;
            else if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            if (redirect_valid) wr_ptr_q <= '0;
            else if (push)      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: FIFO storage has no reset; the head outputs are gated by inst_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= resp_pc_q;
            fifo_data[wr_ptr_q] <= mem_rdata;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (grant)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning instruction address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries and in-flight credit limit; power of 2, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-005 SHALL use one clock; reset is asynchronous and active-low: clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port redirect_valid, input, 1 bit, jump/branch taken.
REQ-008 SHALL have port redirect_addr, input, ADDR_W bits, jump/branch target.
REQ-009 SHALL have port mem_req, output, 1 bit, fetch request to ROM.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits, fetch address.
REQ-011 SHALL have port mem_gnt, input, 1 bit, request accepted this cycle.
REQ-012 SHALL have port mem_rvalid, input, 1 bit, in-order response data valid.
REQ-013 SHALL have port mem_rdata, input, DATA_W bits, response data.
REQ-014 SHALL have port inst_valid, output, 1 bit, FIFO head valid.
REQ-015 SHALL have port inst_pc, output, ADDR_W bits, FIFO head PC.
REQ-016 SHALL have port inst_data, output, DATA_W bits, FIFO head instruction.
REQ-017 SHALL have port inst_ready, input, 1 bit, decode consumes head; low = stall.

Function
REQ-018 SHALL implement states BOOT, RUN and DRAIN: BOOT->RUN after one cycle; RUN->DRAIN on redirect with surviving in-flight count >0; DRAIN->RUN when the discard count reaches 0.
REQ-019 SHALL drive mem_req = (state==RUN) & (occupancy + outstanding < DEPTH) & !redirect_valid, combinationally.
REQ-020 SHALL drive mem_addr = fetch_pc, and increment fetch_pc by 4 (modulo 2^ADDR_W) on each mem_req & mem_gnt.
REQ-021 SHALL hold mem_addr stable while mem_req is high without mem_gnt.
REQ-022 SHALL push each mem_rvalid response into the FIFO unless it is discarded, tagged with resp_pc, then increment resp_pc by 4.
REQ-023 SHALL pop the FIFO on inst_valid & inst_ready, with push and pop allowed in the same cycle when the FIFO is full.
REQ-024 SHALL give a latency of one cycle from mem_rvalid to inst_valid when the FIFO is empty; there SHALL be no combinational rdata-to-inst path.
REQ-025 SHALL, on redirect_valid, clear the FIFO, set fetch_pc and resp_pc to {redirect_addr[ADDR_W-1:2], 2'b00}, and set discard = outstanding - mem_rvalid; redirect SHALL take priority over a same-cycle pop and push.
REQ-026 SHALL treat a redirect during DRAIN as updating the PCs only, with the drain continuing.
REQ-027 SHALL, while discard > 0, drop every mem_rvalid and decrement discard.
REQ-028 SHALL ignore mem_rvalid when outstanding == 0 (protocol error; no state change).
REQ-029 SHALL never exceed DEPTH for outstanding + occupancy.

Reset
REQ-030 SHALL, on rst low, asynchronously set state=BOOT, fetch_pc=resp_pc=RESET_PC, occupancy=outstanding=discard=0, mem_req=0 and inst_valid=0; inst_pc and inst_data SHALL then be 0.
REQ-031 SHALL ensure that reset asserted mid-operation discards all FIFO content and in-flight tracking, and that the first request after release is RESET_PC, issued in the second cycle.

Configuration
REQ-032 SHALL support macro IF_PREFETCH_PERF_EN which, when defined, adds outputs perf_fetch_cnt (32 bits, counts mem_gnt handshakes) and perf_flush_cnt (32 bits, counts redirects), both wrapping and reset to 0.
REQ-033 SHALL, when IF_PREFETCH_PERF_EN is undefined, omit these ports and counters and leave all other behaviour identical.

Verification
REQ-034 SHALL verify reset release with mem_gnt=1 and 1-cycle rvalid: mem_addr 0x0,0x4,0x8...; inst_pc 0x0 first visible 3 cycles after release.
REQ-035 SHALL verify DEPTH=4 with inst_ready=0: exactly 4 grants then mem_req=0; raising inst_ready for one pop re-enables one request.
REQ-036 SHALL verify a redirect to 0x103 with 2 outstanding: fetch address 0x100, next 2 rvalids dropped, DRAIN held until then, first inst_pc 0x100.
REQ-037 SHALL verify a redirect in the same cycle as a pop and an rvalid: FIFO empty next cycle and the response discarded.
REQ-038 SHALL verify fetch_pc=0xFFFFFFFC granted: next mem_addr 0x0 (wrap).
REQ-039 SHALL verify, with IF_PREFETCH_PERF_EN, that 10 grants and 2 redirects give perf_fetch_cnt=10 and perf_flush_cnt=2.
